led_breath_ctrl: RTL and testbench

- Single-LED mode controller and PWM generator, driven by a command handshake.
- Sequences four modes: OFF, ON, BLINK and BREATH (ramp up, hold, ramp down, hold).
- Duty changes and mode changes take effect only at PWM-period boundaries, so the LED output never glitches.
- Sits between the board control logic (key decoder or UART command parser) and an LED pin.

---
 rtl/led_breath_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_led_breath_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_breath_ctrl.sv
// led_breath_ctrl
//   Single-LED mode controller and PWM generator. Commands arrive over a
//   valid/ready handshake and are applied only at PWM-period boundaries, so
//   the LED waveform never glitches. Modes: OFF, ON, BLINK, BREATH.
//
//   Optional feature macro: LED_BREATH_GAMMA_EN
//     defined   -> duty_eff = (duty*duty) >> PWM_BITS (perceptual fade),
//                  product registered at period_end
//     undefined -> duty_eff = duty, no multiplier
//
//   Ports
//     sys_clk     in   system clock
//     sys_rst_n   in   asynchronous active-low reset
//     cmd_valid   in   command request
//     cmd_ready   out  controller can accept a command
//     cmd_mode    in   0=OFF 1=ON 2=BLINK 3=BREATH
//     cmd_step    in   per-period duty increment in BREATH (0 acts as 1)
//     led         out  registered PWM output
//     state       out  current FSM state
//     cycle_done  out  1-cycle pulse at end of each full breath/blink cycle
module led_breath_ctrl #(
    parameter int CLK_DIV      = 50,
    parameter int PWM_BITS     = 8,
    parameter int HOLD_PERIODS = 64
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [PWM_BITS-1:0] cmd_step,
    output logic                led,
    output logic [2:0]          state,
    output logic                cycle_done
);

    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HOLD_EFF = (HOLD_PERIODS < 1) ? 1 : HOLD_PERIODS;
    localparam int HOLD_W   = $clog2(HOLD_EFF + 1);

    localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_EFF - 1);
    localparam logic [PWM_BITS-1:0] DMAX      = '1;

    localparam logic [2:0] S_OFF       = 3'd0;
    localparam logic [2:0] S_ON        = 3'd1;
    localparam logic [2:0] S_BLINK_HI  = 3'd2;
    localparam logic [2:0] S_BLINK_LO  = 3'd3;
    localparam logic [2:0] S_RAMP_UP   = 3'd4;
    localparam logic [2:0] S_HOLD_HI   = 3'd5;
    localparam logic [2:0] S_RAMP_DOWN = 3'd6;
    localparam logic [2:0] S_HOLD_LO   = 3'd7;

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_ON    = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;

    logic [DIV_W-1:0]    div_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty, step;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                pend_vld;
    logic [1:0]          pend_mode;
    logic [PWM_BITS-1:0] pend_step;

    logic tick, period_end, hold_last;
    logic [PWM_BITS:0]   sum;
    logic [PWM_BITS-1:0] duty_eff;

    logic [2:0]          state_nxt;
    logic [PWM_BITS-1:0] duty_nxt, step_nxt;
    logic [HOLD_W-1:0]   hold_nxt;
    logic                done_nxt;

    assign tick       = (div_cnt == DIV_LAST);
    assign period_end = tick && (pwm_cnt == DMAX);
    assign hold_last  = (hold_cnt == HOLD_LAST);
    // One extra bit so the ramp-up sum can be saturated instead of wrapping.
    assign sum        = {1'b0, duty} + {1'b0, step};

    // Next-state values; only committed on period_end. A pending command
    // overrides the normal sequence (aborts cleanly, no cycle_done).
    always_comb begin
        state_nxt = state;
        duty_nxt  = duty;
        step_nxt  = step;
        hold_nxt  = hold_cnt;
        done_nxt  = 1'b0;
        if (pend_vld) begin
            hold_nxt = '0;
            case (pend_mode)
                M_OFF:   begin duty_nxt = '0;   state_nxt = S_OFF;      end
                M_ON:    begin duty_nxt = DMAX; state_nxt = S_ON;       end
                M_BLINK: begin duty_nxt = DMAX; state_nxt = S_BLINK_HI; end
                default: begin
                    // duty kept as-is for a smooth handover into the ramp
                    step_nxt  = (pend_step == '0) ? PWM_BITS'(1) : pend_step;
                    state_nxt = S_RAMP_UP;
                end
            endcase
        end else begin
            case (state)
                S_RAMP_UP: begin
                    if (sum >= {1'b0, DMAX}) begin
                        duty_nxt  = DMAX;
                        state_nxt = S_HOLD_HI;
                        hold_nxt  = '0;
                    end else begin
                        duty_nxt = sum[PWM_BITS-1:0];
                    end
                end
                S_HOLD_HI: begin
                    if (hold_last) begin
                        state_nxt = S_RAMP_DOWN;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                S_RAMP_DOWN: begin
                    if (duty <= step) begin
                        duty_nxt  = '0;
                        state_nxt = S_HOLD_LO;
                        hold_nxt  = '0;
                    end else begin
                        duty_nxt = duty - step;
                    end
                end
                S_HOLD_LO: begin
                    if (hold_last) begin
                        state_nxt = S_RAMP_UP;
                        hold_nxt  = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                S_BLINK_HI: begin
                    if (hold_last) begin
                        duty_nxt  = '0;
                        state_nxt = S_BLINK_LO;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                S_BLINK_LO: begin
                    if (hold_last) begin
                        duty_nxt  = DMAX;
                        state_nxt = S_BLINK_HI;
                        hold_nxt  = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt    <= '0;
            pwm_cnt    <= '0;
            duty       <= '0;
            step       <= '0;
            hold_cnt   <= '0;
            pend_vld   <= 1'b0;
            pend_mode  <= '0;
            pend_step  <= '0;
            cmd_ready  <= 1'b1;
            state      <= S_OFF;
            cycle_done <= 1'b0;
            led        <= 1'b0;
        end else begin
            div_cnt    <= tick ? '0 : div_cnt + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
            cycle_done <= 1'b0;
            led        <= (duty == DMAX) || (pwm_cnt < duty_eff);

            // cmd_ready mirrors !pend_vld, so accept and apply never collide;
            // pend_vld rises after the accept edge, giving "strictly after".
            if (cmd_valid && cmd_ready) begin
                pend_vld  <= 1'b1;
                pend_mode <= cmd_mode;
                pend_step <= cmd_step;
                cmd_ready <= 1'b0;
            end

            if (period_end) begin
                state      <= state_nxt;
                duty       <= duty_nxt;
                step       <= step_nxt;
                hold_cnt   <= hold_nxt;
                cycle_done <= done_nxt;
                if (pend_vld) begin
                    pend_vld  <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            end
        end
    end

`ifdef LED_BREATH_GAMMA_EN
    // Square the upcoming duty so the product lines up with the new period.
    logic [2*PWM_BITS-1:0] duty_sq;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            duty_sq <= '0;
        else if (period_end)
            duty_sq <= {{PWM_BITS{1'b0}}, duty_nxt} * {{PWM_BITS{1'b0}}, duty_nxt};
    end

    assign duty_eff = duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign duty_eff = duty;
`endif

endmodule

// File: tb/tb_led_breath_ctrl.sv
module tb_led_breath_ctrl;

    localparam int CLK_DIV = 2, PWM_BITS = 4, HOLD_PERIODS = 2;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_step;
    logic       led;
    logic [2:0] state;
    logic       cycle_done;

    led_breath_ctrl #(
        .CLK_DIV(CLK_DIV), .PWM_BITS(PWM_BITS), .HOLD_PERIODS(HOLD_PERIODS)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_step(cmd_step),
        .led(led), .state(state), .cycle_done(cycle_done)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference timebase: m_pe high between edges means the next posedge is a period_end.
    int   m_div, m_pwm;
    logic m_pe;
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_div <= 0;
            m_pwm <= 0;
        end else if (m_div == CLK_DIV - 1) begin
            m_div <= 0;
            m_pwm <= (m_pwm + 1) % 16;
        end else begin
            m_div <= m_div + 1;
        end
    end
    assign m_pe = (m_div == CLK_DIV - 1) && (m_pwm == 15);

    // Scoreboard: expected state sequence pushed with each command/reset,
    // popped whenever the DUT state changes.
    logic [2:0] st_q[$];
    logic [2:0] prev_st = 3'd0;
    int         cd_cnt = 0, hi_cnt = 0;

    always @(negedge sys_clk) begin
        if (sys_rst_n === 1'b1) begin
            if (cycle_done === 1'b1) cd_cnt++;
            if (led === 1'b1) hi_cnt++;
        end
        if (state !== prev_st) begin
            if (st_q.size() == 0) check("st_unexpected", 32'(state), 32'(prev_st));
            else                  check("st_seq", 32'(state), 32'(st_q.pop_front()));
            prev_st = state;
        end
    end

    task automatic send_cmd(input logic [1:0] mode, input logic [3:0] stp);
        int n = 0;
        @(negedge sys_clk);
        while (!(cmd_ready === 1'b1 && !m_pe) && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        check("rdy_wait", 32'(n < 200), 1);
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_step  = stp;
        @(posedge sys_clk);
        @(negedge sys_clk);
        cmd_valid = 1'b0;
        check("rdy_drop", 32'(cmd_ready), 0);
    endtask

    // Returns 1 ns after the next period_end edge.
    task automatic wait_pe();
        int n = 0;
        while (!m_pe && n < 200) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        check("pe_found", 32'(m_pe), 1);
        @(posedge sys_clk);
        #1;
    endtask

    // Counts led high over one full PWM period following a period_end.
    task automatic measure(output int hi);
        hi = 0;
        repeat (32) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            if (led === 1'b1) hi++;
        end
    endtask

    int hi, h0, h1, c0, lat;
    int breath_exp[10] = '{0, 10, 20, 32, 32, 32, 20, 10, 0, 0};

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        cmd_step  = 4'd0;
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_led", 32'(led), 0);
        check("rst_state", 32'(state), 0);
        check("rst_rdy", 32'(cmd_ready), 1);
        check("rst_cd", 32'(cycle_done), 0);
        @(negedge sys_clk) sys_rst_n = 1'b1;

        // idle
        @(posedge sys_clk); #1;
        h0 = hi_cnt; c0 = cd_cnt;
        repeat (100) @(posedge sys_clk);
        #1;
        check("idle_led", 32'(hi_cnt - h0), 0);
        check("idle_cd", 32'(cd_cnt - c0), 0);
        check("idle_state", 32'(state), 0);
        check("idle_rdy", 32'(cmd_ready), 1);

        // ON
        st_q.push_back(3'd1);
        send_cmd(2'd1, 4'd0);
        wait_pe();
        check("on_rdy_back", 32'(cmd_ready), 1);
        @(negedge sys_clk);
        check("on_state", 32'(state), 1);
        measure(hi);
        check("on_led", 32'(hi), 32);

        // OFF
        st_q.push_back(3'd0);
        send_cmd(2'd0, 4'd0);
        wait_pe();
        measure(hi);
        check("off_led", 32'(hi), 0);

        // BREATH step 5 from duty 0
        st_q.push_back(3'd4); st_q.push_back(3'd5); st_q.push_back(3'd6);
        st_q.push_back(3'd7); st_q.push_back(3'd4);
        send_cmd(2'd3, 4'd5);
        wait_pe();
        c0 = cd_cnt;
        for (int p = 0; p < 10; p++) begin
            measure(hi);
            check($sformatf("breath_p%0d", p), 32'(hi), 32'(breath_exp[p]));
        end
        @(posedge sys_clk); #1;
        check("breath_cd", 32'(cd_cnt - c0), 1);
        check("cd_single", 32'(cycle_done), 0);

        // abort mid-ramp: no cycle_done
        st_q.push_back(3'd0);
        send_cmd(2'd0, 4'd0);
        wait_pe();
        @(posedge sys_clk); #1;
        check("abort_cd", 32'(cd_cnt - c0), 1);

        // BLINK, OFF during second high period, ignored extra command
        st_q.push_back(3'd2);
        send_cmd(2'd2, 4'd0);
        wait_pe();
        h0 = hi_cnt; c0 = cd_cnt;
        measure(hi);
        check("blink_hi1", 32'(hi), 32);
        st_q.push_back(3'd0);
        send_cmd(2'd0, 4'd0);
        cmd_valid = 1'b1;
        cmd_mode  = 2'd1;
        repeat (3) @(negedge sys_clk);
        check("ign_rdy", 32'(cmd_ready), 0);
        cmd_valid = 1'b0;
        wait_pe();
        @(posedge sys_clk); #1;
        check("blink_hi64", 32'(hi_cnt - h0), 64);
        h1 = hi_cnt;
        repeat (40) @(posedge sys_clk);
        #1;
        check("blink_off_low", 32'(hi_cnt - h1), 0);
        check("blink_cd", 32'(cd_cnt - c0), 0);
        check("blink_state", 32'(state), 0);
        check("blink_rdy", 32'(cmd_ready), 1);

        // accept coinciding with period_end waits a full period
        st_q.push_back(3'd1);
        lat = 0;
        while (!(m_pe && cmd_ready === 1'b1) && lat < 200) begin
            @(posedge sys_clk); #1;
            lat++;
        end
        cmd_valid = 1'b1;
        cmd_mode  = 2'd1;
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
        check("same_pe_rdy", 32'(cmd_ready), 0);
        lat = 0;
        while (state !== 3'd1 && lat < 100) begin
            @(posedge sys_clk); #1;
            lat++;
        end
        check("same_pe_lat", 32'(lat), 32);

        // reset mid-ramp at duty 10
        st_q.push_back(3'd0);
        send_cmd(2'd0, 4'd0);
        wait_pe();
        st_q.push_back(3'd4);
        send_cmd(2'd3, 4'd5);
        wait_pe();
        wait_pe();
        wait_pe();
        repeat (8) @(negedge sys_clk);
        check("pre_rst_led", 32'(led), 1);
        #2;
        st_q.push_back(3'd0);
        sys_rst_n = 1'b0;
        #1;
        check("async_led", 32'(led), 0);
        check("async_state", 32'(state), 0);
        check("async_rdy", 32'(cmd_ready), 1);
        check("async_cd", 32'(cycle_done), 0);
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk) sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        h0 = hi_cnt; c0 = cd_cnt;
        repeat (100) @(posedge sys_clk);
        #1;
        check("rst2_led", 32'(hi_cnt - h0), 0);
        check("rst2_cd", 32'(cd_cnt - c0), 0);
        check("rst2_state", 32'(state), 0);
        st_q.push_back(3'd1);
        send_cmd(2'd1, 4'd0);
        wait_pe();
        @(negedge sys_clk);
        check("rst2_on_state", 32'(state), 1);
        measure(hi);
        check("rst2_on_led", 32'(hi), 32);

        repeat (4) @(posedge sys_clk);
        #1;
        check("sb_empty", 32'(st_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
